acc_core_hs: RTL

- Parametrised successor to the current 8-bit accumulator processor.
- Single-accumulator CPU with one data/address width W and a multicycle fetch/decode/memory FSM.
- Shares one memory port with an explicit req/ack handshake, so memory may insert any number of wait states.
- Sits between the system memory/bus and the debug/status logic; exports acc, pc, flags and halt status.

---
 rtl/acc_core_hs.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/acc_core_hs.sv
// acc_core_hs: single-accumulator CPU with width W and a multicycle fetch/decode/memory FSM on a req/ack memory port.
// Define ACC_CORE_HS_TRAP_EN to trap illegal opcodes into HALT with err set; otherwise they execute as NOP.
//
// state    | meaning
// S_FETCH  | request instruction at pc, latch into ir on ack
// S_DECODE | execute register ops, dispatch memory ops, or halt
// S_MEM    | data access at operand address, complete op on ack
// S_HALT   | frozen until reset
module acc_core_hs #(
   parameter int W      = 8,
   parameter int PC_RST = 0
) (
   input  logic         clk,
   input  logic         clr,
   output logic         mem_req,
   output logic         mem_we,
   output logic [W-1:0] mem_addr,
   output logic [W-1:0] mem_wdata,
   input  logic [W+7:0] mem_rdata,
   input  logic         mem_ack,
   output logic [W-1:0] acc_out,
   output logic [W-1:0] pc_out,
   output logic         carry,
   output logic         zero,
   output logic         halted,
   output logic         err
);

   typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

   localparam logic [W-1:0] PC_RST_W = W'(PC_RST);

   state_t         state_q;
   logic [W-1:0]   pc_q;
   logic [W-1:0]   acc_q;
   logic [W+7:0]   ir_q;
   logic           carry_q;
   logic           zero_q;

   logic [3:0]     opc;
   logic           illegal;
   logic [W-1:0]   op;
   logic [W-1:0]   m;
   logic [W:0]     sum_imm;
   logic [W:0]     sum_mem;
   logic [W:0]     dif_mem;
   logic [W-1:0]   and_r;
   logic [W-1:0]   or_r;
   logic [W-1:0]   xor_r;

   assign opc     = ir_q[W+7:W+4];
   assign illegal = |ir_q[W+3:W];
   assign op      = ir_q[W-1:0];
   assign m       = mem_rdata[W-1:0];
   assign sum_imm = {1'b0, acc_q} + {1'b0, op};
   assign sum_mem = {1'b0, acc_q} + {1'b0, m};
   // Bit W of the widened difference is the unsigned borrow.
   assign dif_mem = {1'b0, acc_q} - {1'b0, m};
   assign and_r   = acc_q & m;
   assign or_r    = acc_q | m;
   assign xor_r   = acc_q ^ m;

`ifdef ACC_CORE_HS_TRAP_EN
   logic err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_FETCH;
         pc_q    <= PC_RST_W;
         acc_q   <= '0;
         ir_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
`ifdef ACC_CORE_HS_TRAP_EN
         err_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_FETCH: begin
               if (mem_ack) begin
                  ir_q    <= mem_rdata;
                  pc_q    <= pc_q + W'(1);
                  state_q <= S_DECODE;
               end
            end
            S_DECODE: begin
               state_q <= S_FETCH;
               if (illegal) begin
`ifdef ACC_CORE_HS_TRAP_EN
                  err_q   <= 1'b1;
                  state_q <= S_HALT;
`endif
               end else begin
                  case (opc)
                     4'h1: begin acc_q <= op; zero_q <= (op == '0); end
                     4'h9: begin
                        {carry_q, acc_q} <= sum_imm;
                        zero_q           <= (sum_imm[W-1:0] == '0);
                     end
                     4'hA: pc_q <= op;
                     4'hB: if (zero_q) pc_q <= op;
                     4'hC: if (carry_q) pc_q <= op;
                     4'hD: begin acc_q <= ~acc_q; zero_q <= (acc_q == '1); end
                     4'hE: begin
                        {carry_q, acc_q} <= {acc_q, 1'b0};
                        zero_q           <= (acc_q[W-2:0] == '0);
                     end
                     4'hF: state_q <= S_HALT;
                     4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: state_q <= S_MEM;
                     default: ;
                  endcase
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  state_q <= S_FETCH;
                  case (opc)
                     4'h2: begin acc_q <= m; zero_q <= (m == '0); end
                     4'h4: begin
                        {carry_q, acc_q} <= sum_mem;
                        zero_q           <= (sum_mem[W-1:0] == '0);
                     end
                     4'h5: begin
                        acc_q   <= dif_mem[W-1:0];
                        carry_q <= dif_mem[W];
                        zero_q  <= (dif_mem[W-1:0] == '0);
                     end
                     4'h6: begin acc_q <= and_r; carry_q <= 1'b0; zero_q <= (and_r == '0); end
                     4'h7: begin acc_q <= or_r;  carry_q <= 1'b0; zero_q <= (or_r == '0); end
                     4'h8: begin acc_q <= xor_r; carry_q <= 1'b0; zero_q <= (xor_r == '0); end
                     default: ;
                  endcase
               end
            end
            S_HALT: ;
            default: state_q <= S_FETCH;
         endcase
      end
   end

   // Gated by clr so the request drops the instant reset asserts.
   assign mem_req   = clr && ((state_q == S_FETCH) || (state_q == S_MEM));
   assign mem_we    = (state_q == S_MEM) && (opc == 4'h3);
   assign mem_addr  = (state_q == S_MEM) ? op : pc_q;
   assign mem_wdata = acc_q;
   assign acc_out   = acc_q;
   assign pc_out    = pc_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign halted    = (state_q == S_HALT);

endmodule
